// File: rtl/refresh_pkg.sv
// Shared types and sizing helpers for the multi-rank refresh scheduler.
package refresh_pkg;

  typedef enum logic [1:0] {
    URG_NONE    = 2'd0,
    URG_PENDING = 2'd1,
    URG_HIGH    = 2'd2,
    URG_FORCE   = 2'd3
  } urgency_t;

  // Signed width that holds -max_pre .. +max_post.
  function automatic int credit_w(input int max_post, input int max_pre);
    int m;
    m = (max_post > max_pre) ? max_post : max_pre;
    return $clog2(m + 1) + 1;
  endfunction

  function automatic int rank_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/refresh_scheduler_if.sv
// Scheduler-facing and command-generator-facing signals of the refresh scheduler.
interface refresh_scheduler_if #(
  parameter int NUM_RANKS = 2
);
  import refresh_pkg::*;

  localparam int RANK_W = rank_w(NUM_RANKS);

  logic [NUM_RANKS-1:0]   ref_req;
  logic [2*NUM_RANKS-1:0] urgency;
  logic [NUM_RANKS-1:0]   block_rank;
  logic                   ref_valid;
  logic [RANK_W-1:0]      ref_rank;
  logic                   ref_ready;

  modport master (
    input  ref_req, ref_ready,
    output urgency, block_rank, ref_valid, ref_rank
  );

  modport slave (
    output ref_req, ref_ready,
    input  urgency, block_rank, ref_valid, ref_rank
  );

endinterface

// File: rtl/refresh_rank_credit.sv
// Per-rank signed refresh credit with saturation at the postpone limit and registered urgency.
module refresh_rank_credit
  import refresh_pkg::*;
#(
  parameter int MAX_POSTPONE = 8,
  parameter int MAX_PREPONE  = 8,
  parameter int CRED_W       = credit_w(MAX_POSTPONE, MAX_PREPONE)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     tick,
  input  logic                     dec,
  output logic signed [CRED_W-1:0] credit,
  output urgency_t                 urgency,
  output logic                     ovf
);

  localparam logic signed [CRED_W-1:0] CMAX  = CRED_W'(MAX_POSTPONE);
  localparam logic signed [CRED_W-1:0] CHALF = CRED_W'(MAX_POSTPONE / 2);
  localparam logic signed [CRED_W-1:0] CZERO = '0;
  localparam logic signed [CRED_W-1:0] CONE  = CRED_W'(1);

  logic signed [CRED_W-1:0] credit_nxt;

  function automatic urgency_t urg_of(input logic signed [CRED_W-1:0] c);
    if (c <= CZERO) return URG_NONE;
    if (c <= CHALF) return URG_PENDING;
    if (c < CMAX)   return URG_HIGH;
    return URG_FORCE;
  endfunction

  // Tick and accept together cancel; a tick at the limit is absorbed.
  always_comb begin
    credit_nxt = credit;
    if (tick && !dec) begin
      if (credit != CMAX) credit_nxt = credit + CONE;
    end else if (dec && !tick) begin
      credit_nxt = credit - CONE;
    end
  end

  assign ovf = tick && (credit == CMAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit  <= '0;
      urgency <= URG_NONE;
    end else begin
      credit  <= credit_nxt;
      urgency <= urg_of(credit_nxt);
    end
  end

endmodule

// File: rtl/refresh_scheduler.sv
// Multi-rank refresh scheduler: tREFI interval counter, per-rank credits, arbiter and command FSM.
// Optional REFRESH_SCHEDULER_STATS_EN adds saturating forced/preponed refresh counters.
module refresh_scheduler
  import refresh_pkg::*;
#(
  parameter int NUM_RANKS    = 2,
  parameter int TREFI_CYCLES = 7800,
  parameter int MAX_POSTPONE = 8,
  parameter int MAX_PREPONE  = 8,
  parameter int STAGGER      = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  refresh_scheduler_if.master  bus,
  output logic                 overflow_err
`ifdef REFRESH_SCHEDULER_STATS_EN
  ,
  output logic [15:0]          stat_forced,
  output logic [15:0]          stat_preponed
`endif
);

  localparam int RANK_W  = rank_w(NUM_RANKS);
  localparam int CRED_W  = credit_w(MAX_POSTPONE, MAX_PREPONE);
  localparam int CNT_W   = (TREFI_CYCLES > 1) ? $clog2(TREFI_CYCLES) : 1;
  localparam int SPACING = (STAGGER != 0) ? TREFI_CYCLES / NUM_RANKS : 0;
  localparam logic signed [CRED_W-1:0] CMAX  = CRED_W'(MAX_POSTPONE);
  localparam logic signed [CRED_W-1:0] CMIN  = CRED_W'(-MAX_PREPONE);
  localparam logic signed [CRED_W-1:0] CZERO = '0;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [NUM_RANKS-1:0]     tick_q, dec, ovf, blk_vec;
  logic [2*NUM_RANKS-1:0]   urg_vec;
  logic signed [CRED_W-1:0] credit [NUM_RANKS];
  urgency_t                 urg [NUM_RANKS];
  logic                     found_f, found_p, found_e, cand_vld;
  logic [RANK_W-1:0]        cand, cand_f, cand_p, cand_e;
  logic signed [CRED_W-1:0] best;
  state_t                   state;
  logic                     valid_q;
  logic [RANK_W-1:0]        rank_q;

  assign cnt_nxt = (cnt == CNT_W'(TREFI_CYCLES - 1)) ? '0 : cnt + CNT_W'(1);

  // Ticks are registered off the next count, so the reset cycle itself never ticks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      tick_q <= '0;
    end else begin
      cnt <= cnt_nxt;
      for (int r = 0; r < NUM_RANKS; r++) tick_q[r] <= (cnt_nxt == CNT_W'(r * SPACING));
    end
  end

  assign dec = (valid_q && bus.ref_ready) ? (NUM_RANKS'(1) << rank_q) : '0;

  for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
    refresh_rank_credit #(
      .MAX_POSTPONE (MAX_POSTPONE),
      .MAX_PREPONE  (MAX_PREPONE),
      .CRED_W       (CRED_W)
    ) u_credit (
      .clk     (clk),
      .rstn    (rstn),
      .tick    (tick_q[r]),
      .dec     (dec[r]),
      .credit  (credit[r]),
      .urgency (urg[r]),
      .ovf     (ovf[r])
    );
  end

  always_comb begin
    urg_vec = '0;
    blk_vec = '0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      urg_vec[2*r +: 2] = urg[r];
      blk_vec[r]        = (urg[r] == URG_FORCE);
    end
  end

  assign bus.urgency    = urg_vec;
  assign bus.block_rank = blk_vec;
  assign bus.ref_valid  = valid_q;
  assign bus.ref_rank   = rank_q;

  // Forced first, then owed-and-requested by credit, then preponed requests.
  always_comb begin
    found_f = 1'b0; found_p = 1'b0; found_e = 1'b0;
    cand_f  = '0;   cand_p  = '0;   cand_e  = '0;
    best    = '0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      if (!found_f && credit[r] == CMAX) begin
        found_f = 1'b1;
        cand_f  = RANK_W'(r);
      end
      if (bus.ref_req[r] && credit[r] > CZERO && (!found_p || credit[r] > best)) begin
        found_p = 1'b1;
        cand_p  = RANK_W'(r);
        best    = credit[r];
      end
      if (!found_e && bus.ref_req[r] && credit[r] > CMIN) begin
        found_e = 1'b1;
        cand_e  = RANK_W'(r);
      end
    end
    cand_vld = found_f || found_p || found_e;
    cand     = found_f ? cand_f : (found_p ? cand_p : cand_e);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      valid_q <= 1'b0;
      rank_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (cand_vld) begin
          state   <= S_ISSUE;
          valid_q <= 1'b1;
          rank_q  <= cand;
        end
        S_ISSUE: if (bus.ref_ready) begin
          state   <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     overflow_err <= 1'b0;
    else if (|ovf) overflow_err <= 1'b1;
  end

`ifdef REFRESH_SCHEDULER_STATS_EN
  logic forced_q, prepone_q;

  // Command class is captured at selection and counted when the command is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      forced_q      <= 1'b0;
      prepone_q     <= 1'b0;
      stat_forced   <= '0;
      stat_preponed <= '0;
    end else begin
      if (state == S_IDLE && cand_vld) begin
        forced_q  <= found_f;
        prepone_q <= !found_f && !found_p;
      end
      if (valid_q && bus.ref_ready) begin
        if (forced_q && stat_forced != 16'hFFFF)    stat_forced   <= stat_forced + 16'd1;
        if (prepone_q && stat_preponed != 16'hFFFF) stat_preponed <= stat_preponed + 16'd1;
      end
    end
  end
`endif

endmodule
